// File: rtl/mips_core_pkg.sv
// Shared core definitions: branch checkpoint sizing and the branch tag carried
// from decode through execute and into the hazard controller.
package mips_core_pkg;

    localparam int CKPT_NUM_DEFAULT = 4;
    localparam int CKPT_ID_W        = $clog2(CKPT_NUM_DEFAULT);

    // A branch is named by its slot plus the wrap color it was allocated under.
    typedef struct packed {
        logic                 color;
        logic [CKPT_ID_W-1:0] id;
    } branch_tag_t;

endpackage

// File: rtl/branch_checkpoint_allocator.sv
// Circular allocator of branch checkpoint slots: in-order grant at tail,
// out-of-order resolution, in-order retirement at head, and squash on mispredict.
module branch_checkpoint_allocator
    import mips_core_pkg::*;
#(
    parameter int NUM_CKPT = CKPT_NUM_DEFAULT,
    localparam int ID_W    = $clog2(NUM_CKPT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc_req,
    output logic                alloc_gnt,
    output logic [ID_W-1:0]     alloc_id,
    output logic                alloc_color,
    output logic                full,
    input  logic                res_valid,
    input  logic [ID_W-1:0]     res_id,
    input  logic                res_color,
    input  logic                res_mispredict,
    output logic                squash_valid,
    output logic [NUM_CKPT-1:0] squash_mask,
    output logic [NUM_CKPT-1:0] live_mask,
    output logic [ID_W:0]       count
);

    localparam logic [ID_W:0]       PTR_ONE    = {{ID_W{1'b0}}, 1'b1};
    localparam logic [ID_W:0]       FULL_COUNT = (ID_W+1)'(NUM_CKPT);
    localparam logic [NUM_CKPT-1:0] SLOT_ONE   = {{(NUM_CKPT-1){1'b0}}, 1'b1};
    localparam logic [NUM_CKPT-1:0] SLOT_NONE  = {NUM_CKPT{1'b0}};

    // Live slots farther from head than ref_idx; live slots always form a
    // contiguous run starting at head, so distance from head gives age.
    function automatic logic [NUM_CKPT-1:0] younger_mask(
        input logic [NUM_CKPT-1:0] live,
        input logic [ID_W-1:0]     head_idx,
        input logic [ID_W-1:0]     ref_idx
    );
        logic [ID_W-1:0] ref_dist;
        logic [ID_W-1:0] slot_dist;
        younger_mask = {NUM_CKPT{1'b0}};
        ref_dist     = ref_idx - head_idx;
        for (int i = 0; i < NUM_CKPT; i++) begin
            slot_dist       = ID_W'(i) - head_idx;
            younger_mask[i] = live[i] & (slot_dist > ref_dist);
        end
    endfunction

    function automatic logic [ID_W:0] pop_count(input logic [NUM_CKPT-1:0] mask);
        pop_count = {(ID_W+1){1'b0}};
        for (int i = 0; i < NUM_CKPT; i++) begin
            pop_count = pop_count + {{ID_W{1'b0}}, mask[i]};
        end
    endfunction

    logic [ID_W:0]       head_r;
    logic [ID_W:0]       tail_r;
    logic [NUM_CKPT-1:0] live_r;
    logic [NUM_CKPT-1:0] resolved_r;
    logic [NUM_CKPT-1:0] color_r;
    logic [ID_W:0]       count_r;
    logic                squash_valid_r;
    logic [NUM_CKPT-1:0] squash_mask_r;

    logic [ID_W:0]       head_n_s;
    logic [ID_W:0]       tail_n_s;
    logic [NUM_CKPT-1:0] live_n_s;
    logic [NUM_CKPT-1:0] resolved_n_s;
    logic [NUM_CKPT-1:0] color_n_s;
    logic [ID_W:0]       count_n_s;

    logic [ID_W-1:0]     head_idx_s;
    logic [ID_W-1:0]     tail_idx_s;
    logic                full_s;
    logic                res_accept_s;
    logic                mispredict_s;
    logic                gnt_s;
    logic                retire_s;
    logic [NUM_CKPT-1:0] squash_s;
    logic [NUM_CKPT-1:0] gnt_bit_s;
    logic [NUM_CKPT-1:0] retire_bit_s;
    logic [NUM_CKPT-1:0] res_bit_s;
    logic [ID_W:0]       gnt_inc_s;
    logic [ID_W:0]       retire_dec_s;

    assign head_idx_s   = head_r[ID_W-1:0];
    assign tail_idx_s   = tail_r[ID_W-1:0];
    assign full_s       = (count_r == FULL_COUNT);

    // A stale tag (slot reused under the other color) or a dead slot is dropped.
    assign res_accept_s = res_valid & live_r[res_id] & (color_r[res_id] == res_color);
    assign mispredict_s = res_accept_s & res_mispredict;
    assign gnt_s        = rst_n & alloc_req & ~full_s & ~mispredict_s;
    assign retire_s     = live_r[head_idx_s] & resolved_r[head_idx_s];

    assign squash_s     = mispredict_s ? younger_mask(live_r, head_idx_s, res_id) : SLOT_NONE;
    assign gnt_bit_s    = gnt_s ? (SLOT_ONE << tail_idx_s) : SLOT_NONE;
    assign retire_bit_s = retire_s ? (SLOT_ONE << head_idx_s) : SLOT_NONE;
    assign res_bit_s    = res_accept_s ? (SLOT_ONE << res_id) : SLOT_NONE;
    assign gnt_inc_s    = gnt_s ? PTR_ONE : {(ID_W+1){1'b0}};
    assign retire_dec_s = retire_s ? PTR_ONE : {(ID_W+1){1'b0}};

    // The granted slot is never live, so it can't collide with retire or squash bits.
    assign live_n_s     = (live_r & ~retire_bit_s & ~squash_s) | gnt_bit_s;
    assign resolved_n_s = (resolved_r | res_bit_s) & ~gnt_bit_s;
    assign color_n_s    = tail_r[ID_W] ? (color_r | gnt_bit_s) : (color_r & ~gnt_bit_s);
    assign count_n_s    = count_r + gnt_inc_s - retire_dec_s - pop_count(squash_s);

    // Pointer advance: a mispredict rewinds tail to just past the offending branch.
    always_comb begin
        head_n_s = head_r;
        tail_n_s = tail_r;
        if (retire_s) begin
            head_n_s = head_r + PTR_ONE;
        end else begin
            head_n_s = head_r;
        end
        if (mispredict_s) begin
            tail_n_s = {color_r[res_id], res_id} + PTR_ONE;
        end else if (gnt_s) begin
            tail_n_s = tail_r + PTR_ONE;
        end else begin
            tail_n_s = tail_r;
        end
    end

    // Checkpoint state and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_r         <= {(ID_W+1){1'b0}};
            tail_r         <= {(ID_W+1){1'b0}};
            live_r         <= SLOT_NONE;
            resolved_r     <= SLOT_NONE;
            color_r        <= SLOT_NONE;
            count_r        <= {(ID_W+1){1'b0}};
            squash_valid_r <= 1'b0;
            squash_mask_r  <= SLOT_NONE;
        end else begin
            head_r         <= head_n_s;
            tail_r         <= tail_n_s;
            live_r         <= live_n_s;
            resolved_r     <= resolved_n_s;
            color_r        <= color_n_s;
            count_r        <= count_n_s;
            squash_valid_r <= mispredict_s;
            squash_mask_r  <= squash_s;
        end
    end

    assign alloc_gnt    = gnt_s;
    assign alloc_id     = tail_idx_s;
    assign alloc_color  = tail_r[ID_W];
    assign full         = full_s;
    assign squash_valid = squash_valid_r;
    assign squash_mask  = squash_mask_r;
    assign live_mask    = live_r;
    assign count        = count_r;

endmodule

// File: tb/tb_branch_checkpoint_allocator.sv
// Directed bench for branch_checkpoint_allocator (NUM_CKPT = 4) with
// hand-computed expectations for grant, resolve, retire, squash and reset.
module tb_branch_checkpoint_allocator;

    logic       clk;
    logic       rst_n;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [1:0] alloc_id;
    logic       alloc_color;
    logic       full;
    logic       res_valid;
    logic [1:0] res_id;
    logic       res_color;
    logic       res_mispredict;
    logic       squash_valid;
    logic [3:0] squash_mask;
    logic [3:0] live_mask;
    logic [2:0] count;

    int n_checks;
    int n_fails;

    branch_checkpoint_allocator #(.NUM_CKPT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_req     (alloc_req),
        .alloc_gnt     (alloc_gnt),
        .alloc_id      (alloc_id),
        .alloc_color   (alloc_color),
        .full          (full),
        .res_valid     (res_valid),
        .res_id        (res_id),
        .res_color     (res_color),
        .res_mispredict(res_mispredict),
        .squash_valid  (squash_valid),
        .squash_mask   (squash_mask),
        .live_mask     (live_mask),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_res(input logic v, input logic [1:0] id, input logic col, input logic mp);
        res_valid      = v;
        res_id         = id;
        res_color      = col;
        res_mispredict = mp;
    endtask

    task automatic idle();
        alloc_req = 1'b0;
        drive_res(1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic expect_grant(input string tag, input logic [1:0] id, input logic col);
        alloc_req = 1'b1;
        #1;
        check_eq({tag, "_gnt"}, 32'(alloc_gnt), 32'd1);
        check_eq({tag, "_id"}, 32'(alloc_id), 32'(id));
        check_eq({tag, "_color"}, 32'(alloc_color), 32'(col));
        tick();
        alloc_req = 1'b0;
    endtask

    task automatic expect_state(input string tag, input logic [3:0] live, input logic [2:0] cnt, input logic sv);
        check_eq({tag, "_live"}, 32'(live_mask), 32'(live));
        check_eq({tag, "_count"}, 32'(count), 32'(cnt));
        check_eq({tag, "_sqv"}, 32'(squash_valid), 32'(sv));
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        idle();
        alloc_req = 1'b1;
        #1;
        check_eq("rst_gnt_blocked", 32'(alloc_gnt), 32'd0);
        tick();
        tick();
        expect_state("rst", 4'b0000, 3'd0, 1'b0);
        check_eq("rst_mask", 32'(squash_mask), 32'd0);
        check_eq("rst_full", 32'(full), 32'd0);
        alloc_req = 1'b0;
        rst_n     = 1'b1;
        tick();

        // Fill all four slots, then a fifth request must stall.
        for (int k = 0; k < 4; k++) begin
            expect_grant("fill", 2'(k), 1'b0);
        end
        expect_state("filled", 4'b1111, 3'd4, 1'b0);
        check_eq("filled_full", 32'(full), 32'd1);
        alloc_req = 1'b1;
        #1;
        check_eq("full_gnt_blocked", 32'(alloc_gnt), 32'd0);
        tick();
        alloc_req = 1'b0;
        check_eq("full_count_hold", 32'(count), 32'd4);

        // Resolve head correctly: resolved next edge, retired the edge after.
        drive_res(1'b1, 2'd0, 1'b0, 1'b0);
        tick();
        idle();
        expect_state("res0_t1", 4'b1111, 3'd4, 1'b0);
        tick();
        expect_state("res0_t2", 4'b1110, 3'd3, 1'b0);
        check_eq("res0_full", 32'(full), 32'd0);
        expect_grant("wrap", 2'd0, 1'b1);
        expect_state("wrap", 4'b1111, 3'd4, 1'b0);

        // Color mismatch on a live slot is ignored.
        drive_res(1'b1, 2'd2, 1'b1, 1'b1);
        tick();
        idle();
        expect_state("badcolor", 4'b1111, 3'd4, 1'b0);

        // Retire slot 1, then a mispredict on the now-dead slot 1 is ignored.
        drive_res(1'b1, 2'd1, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        expect_state("res1", 4'b1101, 3'd3, 1'b0);
        drive_res(1'b1, 2'd1, 1'b0, 1'b1);
        tick();
        idle();
        expect_state("deadslot", 4'b1101, 3'd3, 1'b0);

        // Mispredict on head slot 2 with a request pending: younger slots 3 and 0 squash.
        drive_res(1'b1, 2'd2, 1'b0, 1'b1);
        alloc_req = 1'b1;
        #1;
        check_eq("mp2_gnt_blocked", 32'(alloc_gnt), 32'd0);
        tick();
        idle();
        expect_state("mp2", 4'b0100, 3'd1, 1'b1);
        check_eq("mp2_mask", 32'(squash_mask), 32'b1001);
        // Tail rewound to slot 3; slot 2 retires in the same cycle.
        expect_grant("after_mp2", 2'd3, 1'b0);
        expect_state("after_mp2", 4'b1000, 3'd1, 1'b0);

        // Retire slot 3 while mispredicting slot 0, which squashes slot 1.
        expect_grant("g0", 2'd0, 1'b1);
        expect_grant("g1", 2'd1, 1'b1);
        expect_state("three_live", 4'b1011, 3'd3, 1'b0);
        drive_res(1'b1, 2'd3, 1'b0, 1'b0);
        tick();
        drive_res(1'b1, 2'd0, 1'b1, 1'b1);
        tick();
        idle();
        expect_state("mp_retire", 4'b0001, 3'd1, 1'b1);
        check_eq("mp_retire_mask", 32'(squash_mask), 32'b0010);
        tick();
        expect_state("drained", 4'b0000, 3'd0, 1'b0);

        // Mispredict on the youngest slot: pulse with an empty mask.
        expect_grant("y1", 2'd1, 1'b1);
        expect_grant("y2", 2'd2, 1'b1);
        drive_res(1'b1, 2'd2, 1'b1, 1'b1);
        tick();
        idle();
        expect_state("youngest", 4'b0110, 3'd2, 1'b1);
        check_eq("youngest_mask", 32'(squash_mask), 32'd0);
        expect_grant("y3", 2'd3, 1'b1);

        // Fresh start: ids 0..3 live, mispredict id 1.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_state("rst2", 4'b0000, 3'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            expect_grant("refill", 2'(k), 1'b0);
        end
        drive_res(1'b1, 2'd1, 1'b0, 1'b1);
        tick();
        idle();
        expect_state("mp1", 4'b0011, 3'd2, 1'b1);
        check_eq("mp1_mask", 32'(squash_mask), 32'b1100);
        expect_grant("after_mp1", 2'd2, 1'b0);
        expect_state("after_mp1", 4'b0111, 3'd3, 1'b0);

        // Reset overrides a mispredict and an alloc request in the same cycle.
        drive_res(1'b1, 2'd0, 1'b0, 1'b1);
        alloc_req = 1'b1;
        rst_n     = 1'b0;
        #1;
        check_eq("rst_mp_gnt", 32'(alloc_gnt), 32'd0);
        tick();
        expect_state("rst_mp", 4'b0000, 3'd0, 1'b0);
        check_eq("rst_mp_mask", 32'(squash_mask), 32'd0);
        check_eq("rst_mp_full", 32'(full), 32'd0);
        idle();
        rst_n = 1'b1;
        expect_grant("post_rst", 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
